// File: rtl/sm_loader_pkg.sv
// sm_loader_pkg: shared FSM type and constants for the instruction-memory loader
package sm_loader_pkg;
    localparam int COUNT_W = 16;
    localparam logic [7:0] BROADCAST_ID = 8'hFF;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, SKIP, CHK, DONE} state_t;
endpackage

// File: rtl/sm_byte_packer.sv
// sm_byte_packer: assembles four stream bytes into one little-endian 32-bit word
// word is valid combinationally alongside the fourth byte; the caller registers it.
module sm_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  idx;
    logic [23:0] held;
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            held <= '0;
        end else if (byte_valid) begin
            idx  <= idx + 2'd1;
            held <= {byte_in, held[23:8]};
        end
    end
    assign word       = {byte_in, held};
    assign word_valid = byte_valid && idx == 2'd3;
endmodule

// File: rtl/sm_imem_loader.sv
// sm_imem_loader: filters host-link packets by node ID and writes the program image into imem
// Optional trailing XOR checksum byte enabled by SM_LOADER_CHECKSUM_EN.
module sm_imem_loader
    import sm_loader_pkg::*;
#(
    parameter int SIZE    = 64,
    parameter int NODE_ID = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);
`ifdef SM_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    localparam logic [7:0]       MY_ID = 8'(NODE_ID);
    localparam logic [COUNT_W:0] LIMIT = (COUNT_W + 1)'(SIZE);
    state_t             state;
    logic               own, overflow;
    logic [COUNT_W-1:0] cnt, widx, n_full;
    logic [7:0]         csum;
    logic               xfer, id_hit, in_range, last_word, word_valid;
    logic [31:0]        word;
    assign xfer      = rx_valid && rx_ready;
    assign id_hit    = rx_data == MY_ID || rx_data == BROADCAST_ID;
    assign in_range  = {1'b0, widx} < LIMIT;
    assign last_word = widx + 16'd1 == cnt;
    assign n_full    = {rx_data, cnt[7:0]};
    sm_byte_packer packer (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (rx_data),
        .byte_valid (xfer && (state == DATA || state == SKIP)),
        .word       (word),
        .word_valid (word_valid)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own       <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            widx      <= '0;
            csum      <= '0;
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;
            if (xfer) begin
                case (state)
                    IDLE, DONE: begin
                        own   <= id_hit;
                        widx  <= '0;
                        csum  <= '0;
                        state <= CNT_LO;
                        if (id_hit) begin
                            overflow  <= 1'b0;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            cpu_rst   <= 1'b1;
                        end
                    end
                    CNT_LO: begin
                        cnt[7:0] <= rx_data;
                        csum     <= csum ^ rx_data;
                        state    <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt[15:8] <= rx_data;
                        csum      <= csum ^ rx_data;
                        if (n_full != '0) begin
                            state <= own ? DATA : SKIP;
                        end else begin
                            state <= CKS ? CHK : own ? DONE : IDLE;
                            if (!CKS && own) begin
                                load_done <= 1'b1;
                                cpu_rst   <= 1'b0;
                            end
                        end
                    end
                    DATA, SKIP: begin
                        csum <= csum ^ rx_data;
                        if (word_valid) begin
                            widx <= widx + 16'd1;
                            if (own) begin
                                imem_we   <= in_range;
                                imem_addr <= in_range ? 32'(widx) : imem_addr;
                                imem_wd   <= in_range ? word : imem_wd;
                                overflow  <= overflow || !in_range;
                            end
                            if (last_word) begin
                                state <= CKS ? CHK : own ? DONE : IDLE;
                                if (!CKS && own) begin
                                    load_done <= 1'b1;
                                    cpu_rst   <= 1'b0;
                                    load_err  <= overflow || !in_range;
                                end
                            end
                        end
                    end
                    CHK: begin
                        // Foreign packets only consume their checksum byte.
                        state <= own && csum == rx_data ? DONE : IDLE;
                        if (own) begin
                            load_done <= csum == rx_data;
                            cpu_rst   <= csum != rx_data;
                            load_err  <= csum != rx_data || overflow;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sm_imem_loader.sv
// tb_sm_imem_loader: directed checks of three loaders sharing one byte stream
// u0: NODE_ID=0 SIZE=64, u1: NODE_ID=1 SIZE=64, u2: NODE_ID=0 SIZE=4
module tb_sm_imem_loader;
`ifdef SM_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rdy[3], we[3], crst[3], done[3], err[3];
    logic [31:0] addr[3], wd[3];
    wr_t         log_q[$];
    int          total = 0;
    int          bad = 0;
    int          rdy_miss = 0;
    always #5 clk = ~clk;
    sm_imem_loader #(.SIZE(64), .NODE_ID(0)) u0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy[0]),
        .imem_we(we[0]), .imem_addr(addr[0]), .imem_wd(wd[0]), .cpu_rst(crst[0]),
        .load_done(done[0]), .load_err(err[0]));
    sm_imem_loader #(.SIZE(64), .NODE_ID(1)) u1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy[1]),
        .imem_we(we[1]), .imem_addr(addr[1]), .imem_wd(wd[1]), .cpu_rst(crst[1]),
        .load_done(done[1]), .load_err(err[1]));
    sm_imem_loader #(.SIZE(4), .NODE_ID(0)) u2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy[2]),
        .imem_we(we[2]), .imem_addr(addr[2]), .imem_wd(wd[2]), .cpu_rst(crst[2]),
        .load_done(done[2]), .load_err(err[2]));
    always @(negedge clk)
        for (int k = 0; k < 3; k++)
            if (we[k] === 1'b1) log_q.push_back('{k: 2'(k), a: addr[k], d: wd[k]});
    task automatic drive(input logic [7:0] q[$]);
        foreach (q[i]) begin
            @(negedge clk);
            if (rdy[2] !== 1'b1) rdy_miss++;
            rx_data  = q[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask
    task automatic send_pkt(input logic [7:0] id, input int n, input logic [31:0] w[$], input bit bad_cks);
        logic [7:0] q[$];
        logic [7:0] c;
        q = {id, n[7:0], n[15:8]};
        c = n[7:0] ^ n[15:8];
        foreach (w[i])
            for (int b = 0; b < 4; b++) begin
                q.push_back(w[i][8*b +: 8]);
                c = c ^ w[i][8*b +: 8];
            end
        if (CKS) q.push_back(bad_cks ? c ^ 8'h5A : c);
        drive(q);
    endtask
    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({rdy[k], we[k], addr[k], wd[k], crst[k], done[k], err[k]} !== {2'b00, 64'h0, 3'b100}) begin
                bad++;
                $display("FAIL reset_%0d got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b want 0,0,0,0,1,0,0",
                         k, rdy[k], we[k], addr[k], wd[k], crst[k], done[k], err[k]);
            end
        end
    endtask
    task automatic test_basic;
        logic [31:0] w[$];
        int j0, j2, j1;
        w = {32'h00500293, 32'h00528293, 32'h5e51afa3};
        log_q.delete();
        send_pkt(8'h00, 3, w, 1'b0);
        total++;
        if ({done[0], crst[0], err[0]} !== 3'b100) begin
            bad++; $display("FAIL basic_done got done=%b crst=%b err=%b want 1,0,0", done[0], crst[0], err[0]);
        end
        total++;
        if (we[0] !== !CKS) begin
            bad++; $display("FAIL basic_last_we got=%b want=%b", we[0], !CKS);
        end
        @(negedge clk);
        j0 = 0; j1 = 0; j2 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].k == 2'd0) begin
                total++;
                if (j0 > 2 || log_q[i].a !== 32'(j0) || log_q[i].d !== w[j0]) begin
                    bad++; $display("FAIL basic_wr got addr=%h data=%h want addr=%0d", log_q[i].a, log_q[i].d, j0);
                end
                j0++;
            end
            if (log_q[i].k == 2'd1) j1++;
            if (log_q[i].k == 2'd2) j2++;
        end
        total++;
        if (j0 != 3 || j2 != 3) begin
            bad++; $display("FAIL basic_count got u0=%0d u2=%0d want 3,3", j0, j2);
        end
        total++;
        if (j1 != 0 || crst[1] !== 1'b1 || done[1] !== 1'b0) begin
            bad++; $display("FAIL filter_other got writes=%0d crst=%b done=%b want 0,1,0", j1, crst[1], done[1]);
        end
    endtask
    task automatic test_broadcast;
        logic [31:0] w[$];
        int j1;
        w = {32'h12345678};
        log_q.delete();
        send_pkt(8'hFF, 1, w, 1'b0);
        total++;
        if ({done[1], crst[1], err[1]} !== 3'b100) begin
            bad++; $display("FAIL bcast_done got done=%b crst=%b err=%b want 1,0,0", done[1], crst[1], err[1]);
        end
        @(negedge clk);
        j1 = 0;
        foreach (log_q[i])
            if (log_q[i].k == 2'd1) begin
                total++;
                if (log_q[i].a !== 32'h0 || log_q[i].d !== 32'h12345678) begin
                    bad++; $display("FAIL bcast_wr got addr=%h data=%h want 0 12345678", log_q[i].a, log_q[i].d);
                end
                j1++;
            end
        total++;
        if (j1 != 1) begin
            bad++; $display("FAIL bcast_count got=%0d want=1", j1);
        end
    endtask
    task automatic test_overflow;
        logic [31:0] w[$];
        int j0, j1, j2;
        for (int i = 0; i < 6; i++) w.push_back(32'hA5C30000 | 32'(i * 17));
        log_q.delete();
        rdy_miss = 0;
        send_pkt(8'h00, 6, w, 1'b0);
        total++;
        if ({done[2], crst[2], err[2]} !== 3'b101) begin
            bad++; $display("FAIL ovf_flags got done=%b crst=%b err=%b want 1,0,1", done[2], crst[2], err[2]);
        end
        total++;
        if ({done[0], err[0]} !== 2'b10) begin
            bad++; $display("FAIL ovf_big got done=%b err=%b want 1,0", done[0], err[0]);
        end
        total++;
        if (rdy_miss != 0) begin
            bad++; $display("FAIL ovf_ready got not_ready=%0d want 0", rdy_miss);
        end
        @(negedge clk);
        j0 = 0; j1 = 0; j2 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].k == 2'd2) begin
                total++;
                if (j2 > 3 || log_q[i].a !== 32'(j2) || log_q[i].d !== w[j2]) begin
                    bad++; $display("FAIL ovf_wr got addr=%h data=%h want addr=%0d", log_q[i].a, log_q[i].d, j2);
                end
                j2++;
            end
            if (log_q[i].k == 2'd0) j0++;
            if (log_q[i].k == 2'd1) j1++;
        end
        total++;
        if (j2 != 4 || j0 != 6 || j1 != 0) begin
            bad++; $display("FAIL ovf_count got u0=%0d u1=%0d u2=%0d want 6,0,4", j0, j1, j2);
        end
    endtask
    task automatic test_zero;
        logic [31:0] w[$];
        w.delete();
        log_q.delete();
        send_pkt(8'h00, 0, w, 1'b0);
        total++;
        if ({done[0], crst[0], err[0], done[2], err[2]} !== 5'b10010) begin
            bad++; $display("FAIL zero_done got u0 done=%b crst=%b err=%b u2 done=%b err=%b want 1,0,0,1,0",
                            done[0], crst[0], err[0], done[2], err[2]);
        end
        total++;
        if (done[1] !== 1'b1) begin
            bad++; $display("FAIL zero_other got done=%b want 1", done[1]);
        end
        @(negedge clk);
        total++;
        if (log_q.size() != 0) begin
            bad++; $display("FAIL zero_writes got=%0d want 0", log_q.size());
        end
    endtask
    task automatic test_checksum;
        logic [31:0] w[$];
        w = {32'hDEADBEEF};
        send_pkt(8'h00, 1, w, 1'b1);
        total++;
        if ({done[0], crst[0], err[0]} !== 3'b011) begin
            bad++; $display("FAIL cks_bad got done=%b crst=%b err=%b want 0,1,1", done[0], crst[0], err[0]);
        end
        send_pkt(8'h00, 1, w, 1'b0);
        total++;
        if ({done[0], crst[0], err[0]} !== 3'b100) begin
            bad++; $display("FAIL cks_good got done=%b crst=%b err=%b want 1,0,0", done[0], crst[0], err[0]);
        end
    endtask
    task automatic test_rst_mid;
        logic [7:0]  q[$];
        logic [31:0] w[$];
        int j0;
        q = {8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        drive(q);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rdy[0], we[0], addr[0], wd[0], crst[0], done[0], err[0]} !== {2'b00, 64'h0, 3'b100}) begin
            bad++; $display("FAIL rst_mid got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b want 0,0,0,0,1,0,0",
                            rdy[0], we[0], addr[0], wd[0], crst[0], done[0], err[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        w = {32'hCAFEF00D};
        log_q.delete();
        send_pkt(8'h00, 1, w, 1'b0);
        total++;
        if ({done[0], crst[0], err[0]} !== 3'b100) begin
            bad++; $display("FAIL rst_reload got done=%b crst=%b err=%b want 1,0,0", done[0], crst[0], err[0]);
        end
        @(negedge clk);
        j0 = 0;
        foreach (log_q[i])
            if (log_q[i].k == 2'd0) begin
                total++;
                if (log_q[i].a !== 32'h0 || log_q[i].d !== 32'hCAFEF00D) begin
                    bad++; $display("FAIL rst_wr got addr=%h data=%h want 0 cafef00d", log_q[i].a, log_q[i].d);
                end
                j0++;
            end
        total++;
        if (j0 != 1) begin
            bad++; $display("FAIL rst_count got=%0d want=1", j0);
        end
    endtask
    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic;
        test_broadcast;
        test_overflow;
        test_zero;
        if (CKS) test_checksum;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sm_imem_loader.md
# sm_imem_loader

Boot-time writer for a core's instruction memory: consumes a byte stream from the host link, filters packets by node ID, assembles little-endian 32-bit words and drives the write port of the per-core instruction RAM. Holds its core in reset until a complete program image has been written. One instance sits beside each core's instruction memory in the multicore build. A node with no matching packet keeps its core in reset indefinitely.

## Interface
Parameters:
- SIZE, 64, instruction memory depth in 32-bit words
- NODE_ID, 0, this core's ID; packets with ID byte NODE_ID or 8'hFF (broadcast) are accepted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept; a byte transfers when rx_valid && rx_ready
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  32  word address, 0..SIZE-1
- imem_wd  out  32  word to write
- cpu_rst  out  1  holds the core in reset while high
- load_done  out  1  image fully written (and checksum good, if enabled)
- load_err  out  1  overflow or checksum error of the last matching packet

## Operation
- Packet: ID byte, count low byte, count high byte (16-bit word count N), then 4·N data bytes, little-endian per word (first byte = bits 7:0).
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, SKIP, CHK, DONE.
- IDLE: each transferred byte is an ID. Match -> CNT_LO with own=1. Otherwise -> CNT_LO with own=0.
- CNT_LO/CNT_HI capture N. After CNT_HI: N=0 -> CHK if checksum enabled, else DONE (own) or IDLE (not own). N>0 -> DATA (own) or SKIP (not own).
- DATA: a 2-bit byte index counts bytes; the 4th byte completes a word.
  - Word index < SIZE: word is written at imem_addr = word index.
  - Word index ≥ SIZE: word is consumed but not written; overflow flag is set.
  - After word N: -> CHK or DONE.
- SKIP: consumes 4·N bytes (plus checksum byte if enabled) without writes, then -> IDLE. The outputs of this node are unchanged.
- DONE: load_done=1, cpu_rst=0, load_err=overflow. Stays in DONE; an incoming byte is treated as an ID as in IDLE. A matching ID drops load_done, reasserts cpu_rst, clears load_err, and restarts the load.
- rx_ready = 1 in every state after reset. The loader never backpressures.
- imem_addr wraps never; counters are 16-bit; no write is issued for addresses ≥ SIZE.

## Timing
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wd=0, cpu_rst=1, load_done=0, load_err=0. FSM in IDLE, byte index 0.
- imem_we/imem_addr/imem_wd are registered and asserted in the cycle after the 4th byte transfers. imem_we is high for exactly 1 cycle.
- Back-to-back bytes every cycle are supported: at most one write per 4 cycles.
- load_done and cpu_rst change in the cycle after the final byte (last data byte or checksum byte) transfers. This final write and the load_done rise occur in the same cycle.
- cpu_rst reasserts in the cycle after a matching ID byte transfers in DONE.
- rst mid-packet: returns to reset values next edge. Already-written memory contents are untouched. A partial packet still arriving is parsed from IDLE, so the host must re-send.

## Configuration
- SM_LOADER_CHECKSUM_EN defined:
  - Each packet carries one trailing byte equal to the XOR of all bytes after the ID byte (count and data).
  - CHK compares it. On mismatch: load_err=1, load_done=0, cpu_rst stays 1, FSM -> IDLE.
  - On match: -> DONE, with load_err set only if overflow occurred.
- Undefined: no trailing byte, no CHK state; load_err reports overflow only.

## Structure
- Package sm_loader_pkg: state enum, BROADCAST_ID = 8'hFF, COUNT_W = 16.
- Sub-module sm_byte_packer: 8-bit to 32-bit little-endian shift/assemble with byte index, emits word_valid. The FSM and address counter live in sm_imem_loader.

## Test plan
- NODE_ID=0, packet 00 03 00 + words 00500293, 00528293, 5e51afa3:
  - Three writes, addr 0,1,2, with the exact words.
  - load_done=1 and cpu_rst=0 in the cycle after the last byte.
- NODE_ID=1 receives the same packet (ID 00) -> no imem_we, cpu_rst stays 1. A following packet with ID FF and N=1 -> one write at addr 0, then done.
- SIZE=4, N=6 -> writes only to addr 0..3; all 27 bytes accepted; load_done=1, load_err=1.
- N=0 packet -> no writes, done the cycle after the count high byte (checksum byte 00 if enabled).
- With SM_LOADER_CHECKSUM_EN, a wrong checksum -> load_err=1, load_done=0, cpu_rst=1. A resent correct packet -> done with load_err=0.
- rst asserted after the 2nd data byte -> all outputs return to reset values. A full resent packet then loads correctly.
